tff_toggle_gen: RTL and testbench



---
 rtl/tff_toggle_gen_if.sv | 22 ++
 rtl/tff_toggle_gen.sv | 133 +++++++++++++
 tb/tb_tff_toggle_gen.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/tff_toggle_gen_if.sv
// Button-side signal bundle of the toggle generator: raw button and enable in,
// toggle pulse and debounced level out.
interface tff_toggle_gen_if;
    logic btn_in;
    logic en;
    logic t;
    logic btn_level;

    modport master (
        output btn_in,
        output en,
        input  t,
        input  btn_level
    );

    modport slave (
        input  btn_in,
        input  en,
        output t,
        output btn_level
    );
endinterface

// File: rtl/tff_toggle_gen.sv
// Push-button conditioner for a T flip-flop: synchronises and debounces a raw
// button, then emits single-cycle toggle pulses (optionally auto-repeating).
module tff_toggle_gen #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_CYCLES   = 0
) (
    input  logic           clk,
    input  logic           rst,
    tff_toggle_gen_if.slave bus
);
    localparam int MAX_DR  = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES;
    localparam int MAX_CNT = (MAX_DR > 2) ? MAX_DR : 2;
    localparam int CW      = $clog2(MAX_CNT);

    localparam logic [CW-1:0] D_LAST    = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] R_LAST    = CW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
    localparam bit            REPEAT_ON = (REPEAT_CYCLES != 0);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_CHK,
        HELD,
        REL_CHK
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          sync1;
    logic          btn_s;
    logic [CW-1:0] dcnt;
    logic [CW-1:0] dcnt_next;
    logic [CW-1:0] rcnt;
    logic [CW-1:0] rcnt_next;
    logic          t_q;
    logic          t_next;
    logic          level_q;
    logic          level_next;

    // Two-flop synchroniser; btn_in is asynchronous to clk.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            btn_s <= 1'b0;
        end else begin
            sync1 <= bus.btn_in;
            btn_s <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            dcnt    <= '0;
            rcnt    <= '0;
            t_q     <= 1'b0;
            level_q <= 1'b0;
        end else begin
            state   <= state_next;
            dcnt    <= dcnt_next;
            rcnt    <= rcnt_next;
            t_q     <= t_next;
            level_q <= level_next;
        end
    end

    // Counters are cleared on every state change so a bounce always restarts the check.
    always_comb begin
        state_next = state;
        dcnt_next  = dcnt;
        rcnt_next  = rcnt;
        t_next     = 1'b0;

        case (state)
            IDLE: begin
                if (btn_s) begin
                    state_next = PRESS_CHK;
                    dcnt_next  = '0;
                end
            end
            PRESS_CHK: begin
                if (!btn_s) begin
                    state_next = IDLE;
                    dcnt_next  = '0;
                end else if (dcnt == D_LAST) begin
                    state_next = HELD;
                    t_next     = bus.en;
                    dcnt_next  = '0;
                    rcnt_next  = '0;
                end else begin
                    dcnt_next = dcnt + 1'b1;
                end
            end
            HELD: begin
                if (!btn_s) begin
                    state_next = REL_CHK;
                    dcnt_next  = '0;
                    rcnt_next  = '0;
                end else if (REPEAT_ON) begin
                    if (rcnt == R_LAST) begin
                        t_next    = bus.en;
                        rcnt_next = '0;
                    end else begin
                        rcnt_next = rcnt + 1'b1;
                    end
                end
            end
            REL_CHK: begin
                // A return to 1 here is release bounce: back to HELD without a pulse.
                if (btn_s) begin
                    state_next = HELD;
                    dcnt_next  = '0;
                    rcnt_next  = '0;
                end else if (dcnt == D_LAST) begin
                    state_next = IDLE;
                    dcnt_next  = '0;
                end else begin
                    dcnt_next = dcnt + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                dcnt_next  = '0;
                rcnt_next  = '0;
            end
        endcase

        level_next = (state_next == HELD) || (state_next == REL_CHK);
    end

    assign bus.t         = t_q;
    assign bus.btn_level = level_q;

endmodule

// File: tb/tb_tff_toggle_gen.sv
// Bench for tff_toggle_gen: two instances (no repeat / repeat every 8) driven with
// directed and random button patterns, compared each cycle against a run-length model.
module tb_tff_toggle_gen;
    localparam int DEB = 4;
    localparam int REP = 8;

    logic clk;
    logic rst;

    tff_toggle_gen_if bus0 ();
    tff_toggle_gen_if bus1 ();

    tff_toggle_gen #(.DEBOUNCE_CYCLES(DEB), .REPEAT_CYCLES(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    tff_toggle_gen #(.DEBOUNCE_CYCLES(DEB), .REPEAT_CYCLES(REP)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: the level flips once the synchronised input has disagreed with it
    // for DEB+1 consecutive samples; repeats fire after every REP uninterrupted held samples.
    typedef struct {
        logic s1;
        logic s2;
        logic level;
        int   run;
        int   rep;
        logic t;
    } model_t;

    function automatic model_t model_step(model_t m, logic b_in, logic e, int rep_cycles);
        model_t n;
        logic   b;
        logic   pulse;
        n     = m;
        b     = m.s2;
        pulse = 1'b0;
        n.s2  = m.s1;
        n.s1  = b_in;
        if (!m.level) begin
            if (b) begin
                n.run = m.run + 1;
                if (n.run == DEB + 1) begin
                    n.level = 1'b1;
                    n.run   = 0;
                    n.rep   = 0;
                    pulse   = 1'b1;
                end
            end else begin
                n.run = 0;
            end
        end else begin
            if (!b) begin
                n.run = m.run + 1;
                n.rep = 0;
                if (n.run == DEB + 1) begin
                    n.level = 1'b0;
                    n.run   = 0;
                end
            end else if (m.run > 0) begin
                n.run = 0;
                n.rep = 0;
            end else if (rep_cycles != 0) begin
                if (m.rep == rep_cycles - 1) begin
                    pulse = 1'b1;
                    n.rep = 0;
                end else begin
                    n.rep = m.rep + 1;
                end
            end
        end
        n.t = pulse & e;
        return n;
    endfunction

    model_t m0;
    model_t m1;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m0 = '{default: 0};
            m1 = '{default: 0};
        end else begin
            m0 = model_step(m0, bus0.btn_in, bus0.en, 0);
            m1 = model_step(m1, bus1.btn_in, bus1.en, REP);
        end
    end

    int check_count;
    int fail_count;
    int pulses_dut0;
    int pulses_dut1;
    int pulses_exp0;
    int pulses_exp1;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic checkCycle();
        checkOutput("t0", {31'd0, bus0.t}, {31'd0, m0.t});
        checkOutput("lvl0", {31'd0, bus0.btn_level}, {31'd0, m0.level});
        checkOutput("t1", {31'd0, bus1.t}, {31'd0, m1.t});
        checkOutput("lvl1", {31'd0, bus1.btn_level}, {31'd0, m1.level});
        if (!rst) begin
            checkOutput("rst_t", {31'd0, bus0.t | bus1.t}, 32'd0);
            checkOutput("rst_lvl", {31'd0, bus0.btn_level | bus1.btn_level}, 32'd0);
        end
        pulses_dut0 += int'(bus0.t);
        pulses_dut1 += int'(bus1.t);
        pulses_exp0 += int'(m0.t);
        pulses_exp1 += int'(m1.t);
    endtask

    task automatic applyStimulus(input logic b, input logic e, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            checkCycle();
            bus0.btn_in = b;
            bus1.btn_in = b;
            bus0.en     = e;
            bus1.en     = e;
        end
    endtask

    initial begin
        check_count = 0;
        fail_count  = 0;
        pulses_dut0 = 0;
        pulses_dut1 = 0;
        pulses_exp0 = 0;
        pulses_exp1 = 0;
        rst         = 1'b0;
        bus0.btn_in = 1'b1;
        bus1.btn_in = 1'b1;
        bus0.en     = 1'b1;
        bus1.en     = 1'b1;

        // Button already pressed through reset, then reset released.
        applyStimulus(1'b1, 1'b1, 5);
        rst = 1'b1;
        applyStimulus(1'b1, 1'b1, 15);
        applyStimulus(1'b0, 1'b1, 12);

        // Clean press and release.
        applyStimulus(1'b1, 1'b1, 20);
        applyStimulus(1'b0, 1'b1, 12);

        // Press bounce, then release bounces shorter than the debounce window.
        applyStimulus(1'b1, 1'b1, 2);
        applyStimulus(1'b0, 1'b1, 2);
        applyStimulus(1'b1, 1'b1, 2);
        applyStimulus(1'b0, 1'b1, 2);
        applyStimulus(1'b1, 1'b1, 20);
        applyStimulus(1'b0, 1'b1, 3);
        applyStimulus(1'b1, 1'b1, 2);
        applyStimulus(1'b0, 1'b1, 4);
        applyStimulus(1'b1, 1'b1, 3);
        applyStimulus(1'b0, 1'b1, 12);

        // Press with en low, en raised mid-hold.
        applyStimulus(1'b1, 1'b0, 12);
        applyStimulus(1'b1, 1'b1, 10);
        applyStimulus(1'b0, 1'b1, 12);

        // Long hold for auto-repeat, released mid-period.
        applyStimulus(1'b1, 1'b1, 40);
        applyStimulus(1'b0, 1'b1, 12);

        for (int seg = 0; seg < 80; seg++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                          int'($urandom_range(1, 10)));
        end
        applyStimulus(1'b0, 1'b1, 12);

        // Asynchronous reset while held, asserted between clock edges.
        applyStimulus(1'b1, 1'b1, 12);
        @(posedge clk);
        #2;
        checkOutput("pre_async_lvl", {31'd0, bus0.btn_level}, 32'd1);
        rst = 1'b0;
        #1;
        checkOutput("async_t", {31'd0, bus0.t | bus1.t}, 32'd0);
        checkOutput("async_lvl0", {31'd0, bus0.btn_level}, 32'd0);
        checkOutput("async_lvl1", {31'd0, bus1.btn_level}, 32'd0);
        applyStimulus(1'b1, 1'b1, 3);
        rst = 1'b1;
        applyStimulus(1'b1, 1'b1, 12);
        applyStimulus(1'b0, 1'b1, 12);

        checkOutput("pulse_count0", 32'(pulses_dut0), 32'(pulses_exp0));
        checkOutput("pulse_count1", 32'(pulses_dut1), 32'(pulses_exp1));

        $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
        $finish;
    end

endmodule
